// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - shared types, defaults and helpers for the serial parity receiver
package rx_pkg;

    typedef enum logic {
        DB_LOW  = 1'b0,
        DB_HIGH = 1'b1
    } db_state_e;

    localparam int DEF_SAMPLE_DIV = 100;
    localparam int DEF_DEB_DEPTH  = 4;

    // Callers zero-extend narrower words; zero padding does not change the XOR.
    function automatic logic parity_of(input logic [31:0] vec);
        return ^vec;
    endfunction

endpackage

// File: rtl/serial_parity_rx_if.sv
// rtl/serial_parity_rx_if.sv - serial input and status bundle of the parity receiver
interface serial_parity_rx_if #(
    parameter int WORD_BITS = 5,
    parameter int NUM_WORDS = 4
);
    localparam int N  = NUM_WORDS * WORD_BITS;
    localparam int CW = $clog2(NUM_WORDS + 1);
    localparam int IW = $clog2(N);

    logic          data;
    logic          ready;
    logic [N-1:0]  buff;
    logic [CW-1:0] match_count;
    logic [CW-1:0] frame_count;
    logic [IW-1:0] bit_index;
    logic          bit_strobe;
    logic          frame_done;

    // Board side: drives the raw switch/GPIO lines, watches the status.
    modport master (
        output data, ready,
        input  buff, match_count, frame_count, bit_index, bit_strobe, frame_done
    );

    // Receiver side.
    modport slave (
        input  data, ready,
        output buff, match_count, frame_count, bit_index, bit_strobe, frame_done
    );
endinterface

// File: rtl/ready_debounce.sv
// rtl/ready_debounce.sv - synchronises, samples and debounces the noisy ready line
module ready_debounce
    import rx_pkg::*;
#(
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter int DEB_DEPTH  = DEF_DEB_DEPTH
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ready_i,
    output logic clean_o,
    output logic rise_o
);
    localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [1:0]           sync_q;
    logic [PW-1:0]        presc_q;
    logic                 tick;
    logic [DEB_DEPTH-1:0] samples_q, samples_d;
    db_state_e            state_q, state_d;
    logic                 rise_q;

    assign tick = (presc_q == PW'(SAMPLE_DIV - 1));

    // Synchroniser, prescaler, sample history, debounce state and rise pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q    <= '0;
            presc_q   <= '0;
            samples_q <= '0;
            state_q   <= DB_LOW;
            rise_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], ready_i};
            presc_q   <= tick ? '0 : presc_q + PW'(1);
            samples_q <= samples_d;
            state_q   <= state_d;
            rise_q    <= (state_q == DB_LOW) && (state_d == DB_HIGH);
        end
    end

    // Shift a sample in on each tick; the clean level flips only on a unanimous history.
    always_comb begin
        samples_d = samples_q;
        state_d   = state_q;
        if (tick) begin
            samples_d = {samples_q[DEB_DEPTH-2:0], sync_q[1]};
        end
        case (state_q)
            DB_LOW:  if (&samples_d)  state_d = DB_HIGH;
            DB_HIGH: if (~|samples_d) state_d = DB_LOW;
            default: state_d = DB_LOW;
        endcase
    end

    assign clean_o = (state_q == DB_HIGH);
    assign rise_o  = rise_q;

endmodule

// File: rtl/serial_parity_rx.sv
// rtl/serial_parity_rx.sv - serial word receiver with debounced strobe and parity counter
module serial_parity_rx
    import rx_pkg::*;
#(
    parameter int WORD_BITS  = 5,
    parameter int NUM_WORDS  = 4,
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter int DEB_DEPTH  = DEF_DEB_DEPTH,
    parameter int ODD_PAR    = 0,
    parameter int FRAMED     = 0
) (
    input  logic             CLK,
    input  logic             reset,
    serial_parity_rx_if.slave bus
);
    localparam int   N       = NUM_WORDS * WORD_BITS;
    localparam int   CW      = $clog2(NUM_WORDS + 1);
    localparam int   IW      = $clog2(N);
    localparam logic WANT_PAR = (ODD_PAR != 0);

    logic [1:0]           data_sync_q;
    logic                 clean;
    logic                 rise;
    logic                 shift;
    logic [N-1:0]         buff_q, buff_d;
    logic [IW-1:0]        bit_index_q, bit_index_d;
    logic                 bit_strobe_q;
    logic [CW-1:0]        match_q, match_d;
    logic [CW-1:0]        frame_count_q;
    logic                 frame_done_q;
    logic                 frame_end;
    logic [NUM_WORDS-1:0] word_match;

    ready_debounce #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .DEB_DEPTH  (DEB_DEPTH)
    ) u_ready_debounce (
        .clk_i   (CLK),
        .rst_i   (reset),
        .ready_i (bus.ready),
        .clean_o (clean),
        .rise_o  (rise)
    );

    // rise is only ever raised while clean is high; gating keeps that explicit.
    assign shift = rise & clean;

    // A frame ends on the strobe cycle whose shift wrapped the index back to zero.
    assign frame_end = bit_strobe_q && (bit_index_q == '0);

    for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
        assign word_match[w] = (parity_of(32'(buff_q[w*WORD_BITS +: WORD_BITS])) == WANT_PAR);
    end

    // Population count of matching words; CW always spans 0..NUM_WORDS.
    always_comb begin
        match_d = '0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            match_d = match_d + CW'(word_match[w]);
        end
    end

    // Shift buffer and frame bit index advance together on each clean rise.
    always_comb begin
        buff_d      = buff_q;
        bit_index_d = bit_index_q;
        if (shift) begin
            buff_d      = {buff_q[N-2:0], data_sync_q[1]};
            bit_index_d = (bit_index_q == IW'(N - 1)) ? '0 : bit_index_q + IW'(1);
        end
    end

    // Data synchroniser, buffer, registered count and frame latch.
    always_ff @(posedge CLK) begin
        if (reset) begin
            data_sync_q   <= '0;
            buff_q        <= '0;
            bit_index_q   <= '0;
            bit_strobe_q  <= 1'b0;
            match_q       <= '0;
            frame_count_q <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            data_sync_q  <= {data_sync_q[0], bus.data};
            buff_q       <= buff_d;
            bit_index_q  <= bit_index_d;
            bit_strobe_q <= shift;
            match_q      <= match_d;
            frame_done_q <= 1'b0;
            if ((FRAMED != 0) && frame_end) begin
                frame_done_q  <= 1'b1;
                frame_count_q <= match_d;
            end
        end
    end

    assign bus.buff        = buff_q;
    assign bus.match_count = match_q;
    assign bus.frame_count = frame_count_q;
    assign bus.bit_index   = bit_index_q;
    assign bus.bit_strobe  = bit_strobe_q;
    assign bus.frame_done  = frame_done_q;

endmodule

// File: tb/tb_serial_parity_rx.sv
// tb/tb_serial_parity_rx.sv - self-checking bench for serial_parity_rx
module tb_serial_parity_rx;
    localparam int WB = 5;
    localparam int NW = 4;
    localparam int N  = WB * NW;
    localparam int SD = 4;
    localparam int DD = 4;

    logic clk     = 1'b0;
    logic reset   = 1'b1;
    logic data_r  = 1'b0;
    logic ready_r = 1'b0;

    always #10 clk = ~clk;

    serial_parity_rx_if #(.WORD_BITS(WB), .NUM_WORDS(NW)) if_a ();
    serial_parity_rx_if #(.WORD_BITS(WB), .NUM_WORDS(NW)) if_b ();

    assign if_a.data  = data_r;
    assign if_a.ready = ready_r;
    assign if_b.data  = data_r;
    assign if_b.ready = ready_r;

    serial_parity_rx #(
        .WORD_BITS(WB), .NUM_WORDS(NW), .SAMPLE_DIV(SD), .DEB_DEPTH(DD),
        .ODD_PAR(0), .FRAMED(1)
    ) dut_a (
        .CLK   (clk),
        .reset (reset),
        .bus   (if_a.slave)
    );

    serial_parity_rx #(
        .WORD_BITS(WB), .NUM_WORDS(NW), .SAMPLE_DIV(SD), .DEB_DEPTH(DD),
        .ODD_PAR(1), .FRAMED(0)
    ) dut_b (
        .CLK   (clk),
        .reset (reset),
        .bus   (if_b.slave)
    );

    int tests   = 0;
    int fails   = 0;
    int strobes = 0;
    int frames  = 0;
    int frames_b = 0;
    bit model_q[$];

    always @(negedge clk) begin
        if (if_a.bit_strobe) strobes++;
        if (if_a.frame_done) frames++;
        if (if_b.frame_done) frames_b++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] model_buff();
        logic [N-1:0] v = '0;
        int sz = model_q.size();
        for (int i = 0; i < N && i < sz; i++) v[i] = model_q[sz-1-i];
        return v;
    endfunction

    function automatic int model_match(input int odd);
        logic [N-1:0] v = model_buff();
        int cnt = 0;
        for (int w = 0; w < NW; w++) begin
            int ones = 0;
            for (int b = 0; b < WB; b++) ones += int'(v[w*WB+b]);
            if (ones % 2 == odd) cnt++;
        end
        return cnt;
    endfunction

    task automatic check_state(input string tag);
        check({tag, "_buff_a"},  32'(if_a.buff),        32'(model_buff()));
        check({tag, "_buff_b"},  32'(if_b.buff),        32'(model_buff()));
        check({tag, "_match_a"}, 32'(if_a.match_count), 32'(model_match(0)));
        check({tag, "_match_b"}, 32'(if_b.match_count), 32'(model_match(1)));
        check({tag, "_index_a"}, 32'(if_a.bit_index),   32'(model_q.size() % N));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_q.delete();
        @(negedge clk);
    endtask

    // One clean strobe: raise ready, wait for the shift, sample the frame pulse, drop ready.
    task automatic shift_bit(input logic b, output int lat, output logic fd);
        data_r  = b;
        ready_r = 1'b1;
        lat     = 0;
        while (!if_a.bit_strobe && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("strobe_seen", 32'(if_a.bit_strobe), 32'd1);
        model_q.push_back(b);
        @(negedge clk);
        fd = if_a.frame_done;
        ready_r = 1'b0;
        repeat (40) @(negedge clk);
    endtask

    initial begin
        int          lat;
        int          s0, f0;
        logic        fd, fd_early;
        logic [N-1:0] stream;
        logic [4:0]  bounce;

        // Reset held for three cycles.
        repeat (3) @(negedge clk);
        check("rst_buff",        32'(if_a.buff),        32'd0);
        check("rst_match",       32'(if_a.match_count), 32'd0);
        check("rst_frame_count", 32'(if_a.frame_count), 32'd0);
        check("rst_index",       32'(if_a.bit_index),   32'd0);
        check("rst_strobe",      32'(if_a.bit_strobe),  32'd0);
        check("rst_frame_done",  32'(if_a.frame_done),  32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_match_even", 32'(if_a.match_count), 32'd4);
        check("post_rst_match_odd",  32'(if_b.match_count), 32'd0);

        // Bouncing ready then stable high: exactly one strobe, not early.
        data_r = 1'b1;
        s0     = strobes;
        bounce = 5'b10110;
        for (int i = 4; i >= 0; i--) begin
            ready_r = bounce[i];
            repeat (SD) @(negedge clk);
        end
        ready_r = 1'b1;
        lat = 0;
        while (!if_a.bit_strobe && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("bounce_strobe_seen",  32'(if_a.bit_strobe), 32'd1);
        check("bounce_latency_min",  32'(lat >= (DD - 1) * SD), 32'd1);
        check("bounce_latency_max",  32'(lat <= DD * SD + 8), 32'd1);
        model_q.push_back(1'b1);
        repeat (60) @(negedge clk);
        check("bounce_single_strobe", 32'(strobes - s0), 32'd1);
        ready_r = 1'b0;
        repeat (40) @(negedge clk);
        check_state("bounce");

        // Directed frame 10100 00000 11111 00011, first stream bit first.
        do_reset();
        stream   = 20'hA03E3;
        f0       = frames;
        fd_early = 1'b0;
        fd       = 1'b0;
        for (int i = 0; i < N; i++) begin
            shift_bit(stream[N-1-i], lat, fd);
            if (i < N - 1) fd_early |= fd;
        end
        check("frame_buff",        32'(if_a.buff),        32'h000A03E3);
        check("frame_match_even",  32'(if_a.match_count), 32'd3);
        check("frame_match_odd",   32'(if_b.match_count), 32'd1);
        check("frame_done_20th",   32'(fd),               32'd1);
        check("frame_done_early",  32'(fd_early),         32'd0);
        check("frame_done_once",   32'(frames - f0),      32'd1);
        check("frame_count",       32'(if_a.frame_count), 32'd3);
        check("frame_index_wrap",  32'(if_a.bit_index),   32'd0);
        check("unframed_count",    32'(if_b.frame_count), 32'd0);
        check_state("frame");

        // Reset after 7 random bits, then 20 random bits checked against the model.
        for (int i = 0; i < 7; i++) shift_bit(1'($urandom_range(0, 1)), lat, fd);
        check_state("partial");
        do_reset();
        check("midreset_buff",  32'(if_a.buff),      32'd0);
        check("midreset_index", 32'(if_a.bit_index), 32'd0);
        f0 = frames;
        for (int i = 0; i < N; i++) begin
            shift_bit(1'($urandom_range(0, 1)), lat, fd);
            check_state("rand");
            if (i == N - 1) check("rand_frame_done_20th", 32'(fd), 32'd1);
        end
        check("rand_frame_once",  32'(frames - f0),      32'd1);
        check("rand_frame_count", 32'(if_a.frame_count), 32'(model_match(0)));

        // Ready held high for 1000 cycles with data churning after the shift.
        s0      = strobes;
        data_r  = 1'($urandom_range(0, 1));
        model_q.push_back(data_r);
        ready_r = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (strobes != s0) data_r = 1'($urandom_range(0, 1));
        end
        ready_r = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            data_r = 1'($urandom_range(0, 1));
        end
        check("long_ready_single_shift", 32'(strobes - s0), 32'd1);
        check_state("long_ready");
        check("unframed_never_done", 32'(frames_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
